// File: rtl/gray_tracker_if.sv
// Bundles the Gray-sample inputs and the tracking outputs of gray_tracker.
// The master modport drives samples; the slave modport is the tracker itself.
interface gray_tracker_if #(
  parameter int WIDTH = 4,
  parameter int POS_W = 16,
  parameter int REV_W = 8
);
  logic [WIDTH-1:0] gray;
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] bin;
  logic             valid;
  logic [POS_W-1:0] pos;
  logic [REV_W-1:0] rev;
  logic             up_pulse;
  logic             dn_pulse;
  logic             err_pulse;
  logic             fault;
  logic [7:0]       err_cnt;

  modport master (
    output gray, en, clr,
    input  bin, valid, pos, rev, up_pulse, dn_pulse, err_pulse, fault, err_cnt
  );

  modport slave (
    input  gray, en, clr,
    output bin, valid, pos, rev, up_pulse, dn_pulse, err_pulse, fault, err_cnt
  );
endinterface

// File: rtl/gray_tracker.sv
// Decodes sampled Gray words, tracks position/revolutions from single-bit steps
// and latches a fault on any multi-bit jump until cleared.
module gray_tracker #(
  parameter int WIDTH = 4,
  parameter int POS_W = 16,
  parameter int REV_W = 8
) (
  input logic           clk,
  input logic           rst,
  gray_tracker_if.slave bus
);

  typedef enum logic [1:0] {INIT, TRACK, FAULT} state_t;

  localparam logic [WIDTH-1:0] MAX_BIN = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             valid_q, valid_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [REV_W-1:0] rev_q, rev_d;
  logic             up_q, up_d, dn_q, dn_d, err_q, err_d;
  logic             fault_q, fault_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [WIDTH-1:0] new_bin, old_bin, step;
  int               flips;

  always_comb begin
    // NOTE: every next-state value is defaulted to hold first so no path can infer a latch.
    state_d = state_q;
    ref_d   = ref_q;
    bin_d   = bin_q;
    valid_d = valid_q;
    pos_d   = pos_q;
    rev_d   = rev_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    err_d   = 1'b0;

    new_bin = gray2bin(bus.gray);
    old_bin = gray2bin(ref_q);
    step    = new_bin - old_bin;
    flips   = $countones(bus.gray ^ ref_q);

    if (bus.clr) begin
      // Sample in a clr cycle is discarded; counters survive the re-arm.
      state_d = INIT;
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else if (bus.en) begin
      unique case (state_q)
        INIT: begin
          ref_d   = bus.gray;
          bin_d   = new_bin;
          valid_d = 1'b1;
          state_d = TRACK;
        end
        TRACK: begin
          if (flips == 0) begin
            bin_d = new_bin;
          end else if (flips == 1) begin
            ref_d = bus.gray;
            bin_d = new_bin;
            if (step == ONE) begin
              up_d  = 1'b1;
              pos_d = pos_q + POS_W'(1);
              if (old_bin == MAX_BIN && new_bin == '0) rev_d = rev_q + REV_W'(1);
            end else if (step == MAX_BIN) begin
              dn_d  = 1'b1;
              pos_d = pos_q - POS_W'(1);
              if (old_bin == '0 && new_bin == MAX_BIN) rev_d = rev_q - REV_W'(1);
            end
          end else begin
            // Reference is frozen so the last good position is preserved for diagnosis.
            bin_d   = new_bin;
            err_d   = 1'b1;
            fault_d = 1'b1;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            state_d = FAULT;
          end
        end
        FAULT:   bin_d = new_bin;
        default: state_d = INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      ref_q   <= '0;
      bin_q   <= '0;
      valid_q <= 1'b0;
      pos_q   <= '0;
      rev_q   <= '0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      err_q   <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      ref_q   <= ref_d;
      bin_q   <= bin_d;
      valid_q <= valid_d;
      pos_q   <= pos_d;
      rev_q   <= rev_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      err_q   <= err_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.bin       = bin_q;
  assign bus.valid     = valid_q;
  assign bus.pos       = pos_q;
  assign bus.rev       = rev_q;
  assign bus.up_pulse  = up_q;
  assign bus.dn_pulse  = dn_q;
  assign bus.err_pulse = err_q;
  assign bus.fault     = fault_q;
  assign bus.err_cnt   = cnt_q;

endmodule
